// File: rtl/div_fmt_pkg.sv
// Shared types and constants for the divider result formatter.
// FSM state encoding plus the special digit codes seen by the display driver.
package div_fmt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } fmt_state_t;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] ERR_CODE   = 4'hE;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/div_result_formatter_dabble_step.sv
// One double-dabble step on a two-digit BCD accumulator.
// Adds 3 to any nibble >= 5, then shifts left bringing in bit_in.
module dabble_step
    import div_fmt_pkg::*;
(
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       bit_in,
    output logic [3:0] tens_nxt,
    output logic [3:0] ones_nxt
);

    logic [DIGIT_W-1:0] tens_adj;
    logic [DIGIT_W-1:0] ones_adj;

    assign tens_adj = (tens >= 4'd5) ? tens + 4'd3 : tens;
    assign ones_adj = (ones >= 4'd5) ? ones + 4'd3 : ones;

    assign tens_nxt = {tens_adj[2:0], ones_adj[3]};
    assign ones_nxt = {ones_adj[2:0], bit_in};

endmodule

// File: rtl/div_result_formatter.sv
// Registers divider Q/R/err and converts Q and R to BCD, one bit per clock.
// Define DIV_FMT_LEADING_BLANK_EN to blank zero tens digits in the result.
module div_result_formatter #(
    parameter int         DATA_W     = 4,
    parameter logic [3:0] ERR_CODE   = div_fmt_pkg::ERR_CODE,
    parameter logic [3:0] BLANK_CODE = div_fmt_pkg::BLANK_CODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] q,
    input  logic [DATA_W-1:0] r,
    input  logic              err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        q_tens,
    output logic [3:0]        q_ones,
    output logic [3:0]        r_tens,
    output logic [3:0]        r_ones,
    output logic              out_err
);

    import div_fmt_pkg::*;

    localparam int CNT_W = $clog2(DATA_W + 1);

    fmt_state_t state;
    fmt_state_t state_nxt;

    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  q_sh;
    logic [DATA_W-1:0]  r_sh;
    logic               err_q;
    logic [DIGIT_W-1:0] qt_acc;
    logic [DIGIT_W-1:0] qo_acc;
    logic [DIGIT_W-1:0] rt_acc;
    logic [DIGIT_W-1:0] ro_acc;

    logic [DIGIT_W-1:0] qt_nxt;
    logic [DIGIT_W-1:0] qo_nxt;
    logic [DIGIT_W-1:0] rt_nxt;
    logic [DIGIT_W-1:0] ro_nxt;
    logic [DIGIT_W-1:0] qt_fmt;
    logic [DIGIT_W-1:0] rt_fmt;

    logic accept;
    logic last_step;

    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (bit_cnt == CNT_W'(DATA_W - 1));

    dabble_step u_dabble_q (
        .tens     (qt_acc),
        .ones     (qo_acc),
        .bit_in   (q_sh[DATA_W-1]),
        .tens_nxt (qt_nxt),
        .ones_nxt (qo_nxt)
    );

    dabble_step u_dabble_r (
        .tens     (rt_acc),
        .ones     (ro_acc),
        .bit_in   (r_sh[DATA_W-1]),
        .tens_nxt (rt_nxt),
        .ones_nxt (ro_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = err ? DONE : CONV;
                end
            end
            CONV: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            q_sh    <= '0;
            r_sh    <= '0;
            err_q   <= 1'b0;
            qt_acc  <= '0;
            qo_acc  <= '0;
            rt_acc  <= '0;
            ro_acc  <= '0;
        end else if (accept) begin
            bit_cnt <= '0;
            q_sh    <= q;
            r_sh    <= r;
            err_q   <= err;
            qt_acc  <= '0;
            qo_acc  <= '0;
            rt_acc  <= '0;
            ro_acc  <= '0;
        end else if (state == CONV) begin
            bit_cnt <= last_step ? '0 : bit_cnt + 1'b1;
            q_sh    <= q_sh << 1;
            r_sh    <= r_sh << 1;
            qt_acc  <= qt_nxt;
            qo_acc  <= qo_nxt;
            rt_acc  <= rt_nxt;
            ro_acc  <= ro_nxt;
        end
    end

`ifdef DIV_FMT_LEADING_BLANK_EN
    assign qt_fmt = (qt_acc == '0) ? BLANK_CODE : qt_acc;
    assign rt_fmt = (rt_acc == '0) ? BLANK_CODE : rt_acc;
`else
    assign qt_fmt = qt_acc;
    assign rt_fmt = rt_acc;
`endif

    // Digits are gated to DONE so a partial conversion is never visible.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = 1'b0;
        out_err   = 1'b0;
        q_tens    = '0;
        q_ones    = '0;
        r_tens    = '0;
        r_ones    = '0;
        if (state == DONE) begin
            out_valid = 1'b1;
            out_err   = err_q;
            if (err_q) begin
                q_tens = ERR_CODE;
                q_ones = ERR_CODE;
                r_tens = ERR_CODE;
                r_ones = ERR_CODE;
            end else begin
                q_tens = qt_fmt;
                q_ones = qo_acc;
                r_tens = rt_fmt;
                r_ones = ro_acc;
            end
        end
    end

endmodule
